// File: rtl/i2c_target_pkg.sv
// Shared types and defaults for the I2C register target.
// The FSM state encoding and the default bus address live here.
package i2c_target_pkg;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;
  localparam int         DEF_NREG       = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_e;

endpackage

// File: rtl/i2c_target_if.sv
// Open-drain bus intent from an I2C master: each signal set means "pull the wire low".
// The wired-AND with pull-ups is resolved where the interface is instantiated.
interface i2c_target_if;
  logic scl_low;
  logic sda_low;

  modport master (output scl_low, output sda_low);
  modport slave  (input  scl_low, input  sda_low);
endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus one history flop for rise/fall detection.
// Resets to 1 so an idle (pulled-up) bus produces no edge when reset releases.
module i2c_sync_edge (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], din};

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) sync_q <= 3'b111;
    else        sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing NREG 8-bit registers behind an auto-incrementing pointer.
// state        | meaning
// IDLE         | bus free or after reset; waits for START
// ADDR         | shifting in the address byte
// ADDR_ACK     | acknowledging our address
// PTR          | shifting in the pointer byte
// PTR_ACK      | acknowledging the pointer byte
// WDATA        | shifting in a write byte
// WDATA_ACK    | acknowledging a write byte
// RDATA        | shifting out reg[ptr]
// RDATA_ACK    | master's ACK/NACK slot
// IGNORE       | not addressed or read ended; waits for START/STOP
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int         NREG       = DEF_NREG
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              SCL,
  inout  wire               SDA,
  output logic [8*NREG-1:0] REGS,
  output logic              WR_STB,
  output logic              BUSY
);

  localparam int PW = $clog2(NREG);

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    regs_q [NREG];
  logic [7:0]    regs_d [NREG];
  logic          rw_q, rw_d;
  logic          slot_q, slot_d;
  logic          sda_oe_q, sda_oe_d;
  logic          wr_stb_q, wr_stb_d;
  logic          busy_q, busy_d;

  logic          scl_s, scl_rise, scl_fall;
  logic          sda_s, sda_rise, sda_fall;
  logic          start_det, stop_det;
  logic [7:0]    rx_byte, cur_reg, nxt_reg;
  logic [PW-1:0] ptr_inc;

  i2c_sync_edge u_scl_sync (
    .clk_sys (PCLK),
    .rst_b   (PRESETn),
    .din     (SCL),
    .level   (scl_s),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk_sys (PCLK),
    .rst_b   (PRESETn),
    .din     (SDA),
    .level   (sda_s),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;
  assign rx_byte   = {shift_q[6:0], sda_s};
  assign ptr_inc   = ptr_q + PW'(1);
  assign cur_reg   = regs_q[ptr_q];
  assign nxt_reg   = regs_q[ptr_inc];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    regs_d    = regs_q;
    rw_d      = rw_q;
    slot_d    = slot_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    busy_d    = busy_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      slot_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      slot_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              slot_d = 1'b0;
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte[PW-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_stb_d      = 1'b1;
                ptr_d         = ptr_inc;
                state_d       = ST_WDATA_ACK;
              end
            end
          end
        end

        // slot_q marks that the 9th SCL rise has been seen in this ACK slot
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_rise) begin
            slot_d = 1'b1;
          end else if (scl_fall) begin
            if (!slot_q) begin
              sda_oe_d = 1'b1;
            end else begin
              slot_d    = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d  = ST_RDATA;
                shift_d  = cur_reg;
                sda_oe_d = ~cur_reg[7];
              end else begin
                sda_oe_d = 1'b0;
                state_d  = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_RDATA_ACK;
              slot_d  = 1'b0;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end else begin
              slot_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (!slot_q) begin
              sda_oe_d = 1'b0;
            end else begin
              slot_d    = 1'b0;
              bit_cnt_d = '0;
              ptr_d     = ptr_inc;
              shift_d   = nxt_reg;
              sda_oe_d  = ~nxt_reg[7];
              state_d   = ST_RDATA;
            end
          end
        end

        ST_IDLE, ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      regs_q    <= '{default: '0};
      rw_q      <= 1'b0;
      slot_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      regs_q    <= regs_d;
      rw_q      <= rw_d;
      slot_q    <= slot_d;
      sda_oe_q  <= sda_oe_d;
      wr_stb_q  <= wr_stb_d;
      busy_q    <= busy_d;
    end
  end

  assign SDA    = sda_oe_q ? 1'b0 : 1'bz;
  assign WR_STB = wr_stb_q;
  assign BUSY   = busy_q;

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign REGS[8*g +: 8] = regs_q[g];
  end

endmodule
